phase_sched: RTL and testbench

Sequencer for the single-pass GF(2) systemizer phase engine. On one `start` it issues one phase per N-row pivot block (P = L/N phases), keeping at most two phases in flight so the engine's read-ahead overlap is used. It counts phase completions, latches any pivot failure and reports a single `done` with a `fail` status. It also gates host access to the phase memory so the host touches the matrix only while no phase is running.

---
 rtl/systemizer_pkg.sv | 14 +
 rtl/phase_issue_ctr.sv | 57 +++++
 rtl/phase_sched.sv | 73 +++++++
 tb/tb_phase_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/systemizer_pkg.sv
// systemizer_pkg: shared types, default geometry and width helpers for the phase sequencer.
package systemizer_pkg;
  localparam int DEF_N = 4;
  localparam int DEF_L = 24;
  localparam int DEF_K = 32;
  localparam int P = DEF_L / DEF_N;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, END} state_t;
  function automatic int ctr_w(input int l, input int n);
    return $clog2(l / n + 1);
  endfunction
  function automatic int addr_w(input int l, input int k, input int n);
    return $clog2(l * k / n + 1);
  endfunction
endpackage

// File: rtl/phase_issue_ctr.sv
// phase_issue_ctr: issued/completed phase counters, two-deep in-flight limit and phase address generation.
module phase_issue_ctr
  import systemizer_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int L = DEF_L,
  parameter int K = DEF_K
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       ph_ready,
  input  logic                       ph_done,
  output logic                       ph_start,
  output logic [addr_w(L,K,N)-1:0]   ph_start_block,
  output logic [$clog2(L):0]         ph_rows,
  output logic [ctr_w(L,N)-1:0]      iss,
  output logic [ctr_w(L,N)-1:0]      cmp
);
  localparam int PH = L / N;
  localparam int CW = ctr_w(L, N);
  localparam int AW = addr_w(L, K, N);
  localparam int RW = $clog2(L) + 1;
  logic [CW-1:0] iss_q, iss_d, cmp_q, cmp_d;
  logic [AW-1:0] blk_q, blk_d;
  logic [RW-1:0] rows_q, rows_d;
  logic          start_q, start_d, issue;
  always_comb begin
    issue = en && ph_ready && !start_q && iss_q < CW'(PH) && (iss_q - cmp_q) < CW'(2);
    iss_d = clr ? '0 : iss_q + CW'(issue);
    cmp_d = clr ? '0 : cmp_q + CW'(ph_done);
    start_d = issue;
    blk_d = issue ? AW'(iss_q) * AW'(L) : blk_q;
    rows_d = issue ? RW'(iss_q) * RW'(N) : rows_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q <= '0;
      cmp_q <= '0;
      start_q <= 1'b0;
      blk_q <= '0;
      rows_q <= '0;
    end else begin
      iss_q <= iss_d;
      cmp_q <= cmp_d;
      start_q <= start_d;
      blk_q <= blk_d;
      rows_q <= rows_d;
    end
  end
  assign ph_start = start_q;
  assign ph_start_block = blk_q;
  assign ph_rows = rows_q;
  assign iss = iss_q;
  assign cmp = cmp_q;
endmodule

// File: rtl/phase_sched.sv
// phase_sched: run FSM sequencing one phase per pivot block, failure latch and host memory grant.
module phase_sched
  import systemizer_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int L = DEF_L,
  parameter int K = DEF_K
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic [ctr_w(L,N)-1:0]      phase_idx,
  output logic                       ph_start,
  output logic [addr_w(L,K,N)-1:0]   ph_start_block,
  output logic [$clog2(L):0]         ph_rows,
  input  logic                       ph_ready,
  input  logic                       ph_done,
  input  logic                       ph_fail,
  input  logic                       host_req,
  output logic                       host_gnt
);
  localparam int PH = L / N;
  localparam int CW = ctr_w(L, N);
  state_t        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d, fail_q, fail_d, gnt_q, gnt_d;
  logic          idle, go, stop, en;
  logic [CW-1:0] iss, cmp, cmp_nx;
  phase_issue_ctr #(.N(N), .L(L), .K(K)) u_ctr (
    .clk(clk), .rst_n(rst_n), .clr(go), .en(en), .ph_ready(ph_ready), .ph_done(ph_done),
    .ph_start(ph_start), .ph_start_block(ph_start_block), .ph_rows(ph_rows), .iss(iss), .cmp(cmp)
  );
  always_comb begin
    idle = state_q == IDLE || state_q == END;
    go = idle && start && !host_req;
    stop = fail_q || ph_fail;
    en = state_q == RUN && !stop;
    // a completion arriving this cycle already counts toward the exit conditions
    cmp_nx = cmp + CW'(ph_done);
    case (state_q)
      IDLE, END: state_d = go ? RUN : state_q;
      RUN:       state_d = stop ? (cmp_nx == iss ? END : DRAIN) : (cmp_nx == CW'(PH) ? END : RUN);
      DRAIN:     state_d = cmp_nx == iss ? END : DRAIN;
      default:   state_d = IDLE;
    endcase
    busy_d = state_d == RUN || state_d == DRAIN;
    done_d = state_d == END && state_q != END;
    fail_d = go ? 1'b0 : fail_q || (!idle && ph_fail);
    gnt_d = idle && host_req;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      gnt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      fail_q <= fail_d;
      gnt_q <= gnt_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign fail = fail_q;
  assign host_gnt = gnt_q;
  assign phase_idx = iss;
endmodule

// File: tb/tb_phase_sched.sv
// tb_phase_sched: directed scenarios against a latency-30 phase engine model with hand-computed expectations.
module tb_phase_sched;
  localparam int N = 4, L = 24, K = 32, LAT = 30;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, host_req = 1'b0;
  logic ph_ready = 1'b1, ph_done = 1'b0, ph_fail = 1'b0;
  logic busy, done, fail, ph_start, host_gnt;
  logic [2:0] phase_idx;
  logic [7:0] ph_start_block;
  logic [5:0] ph_rows;
  int tests = 0, errs = 0;
  int cyc = 0, nst = 0, nds = 0, ndone_p = 0, done_nst = 0, done_dn = 0, max_inf = 0, bp_left = 0;
  bit bp_viol = 0;
  int blk[16], rws[16], scyc[16];
  int due[$];
  int fail_on = 0;
  bit fail_last = 0, bp_mode = 0;

  always #5 clk = ~clk;

  phase_sched #(.N(N), .L(L), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .phase_idx(phase_idx), .ph_start(ph_start), .ph_start_block(ph_start_block), .ph_rows(ph_rows),
    .ph_ready(ph_ready), .ph_done(ph_done), .ph_fail(ph_fail), .host_req(host_req), .host_gnt(host_gnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // engine model: every start completes LAT cycles later; optional fail/back-pressure injection
  always @(posedge clk) begin
    #1;
    cyc++;
    ph_done = 1'b0;
    ph_fail = 1'b0;
    if (!rst_n) begin
      nst = 0; nds = 0; ndone_p = 0; max_inf = 0; bp_viol = 0; bp_left = 0;
      due.delete();
      ph_ready = 1'b1;
    end else begin
      if (done) begin
        ndone_p++;
        done_nst = nst;
        done_dn = nds;
      end
      if (ph_start) begin
        if (!ph_ready) bp_viol = 1;
        if (nst < 16) begin
          blk[nst] = int'(ph_start_block);
          rws[nst] = int'(ph_rows);
          scyc[nst] = cyc;
        end
        nst++;
        due.push_back(cyc + LAT);
        if (nst == fail_on) ph_fail = 1'b1;
        if (bp_mode && nst == 1) bp_left = 50;
      end
      if (nst - nds > max_inf) max_inf = nst - nds;
      if (due.size() > 0 && due[0] <= cyc) begin
        void'(due.pop_front());
        ph_done = 1'b1;
        nds++;
        if (fail_last && nds == 6) ph_fail = 1'b1;
      end
      ph_ready = bp_left == 0;
      if (bp_left > 0) bp_left--;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 1000 && !done; i++) tick(1);
    chk(tag, done, 1);
  endtask

  task automatic wait_nst(input int n, input string tag);
    for (int i = 0; i < 500 && nst < n; i++) tick(1);
    chk(tag, nst >= n, 1);
  endtask

  initial begin
    tick(3);
    chk("reset_outputs", {busy, done, fail, phase_idx, ph_start, ph_start_block, ph_rows, host_gnt}, 0);
    rst_n = 1'b1;
    tick(1);
    host_req = 1'b1;
    tick(1);
    chk("host_gnt_idle", host_gnt, 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("start_with_host_ignored", busy, 0);
    host_req = 1'b0;
    tick(2);
    chk("host_gnt_drop", host_gnt, 0);

    pulse_start;
    chk("busy_after_start", busy, 1);
    chk("host_gnt_busy", host_gnt, 0);
    wait_nst(2, "nom_two_issued");
    pulse_start;
    chk("midrun_start_idx", phase_idx, 2);
    chk("midrun_start_busy", busy, 1);
    wait_done("nom_done");
    chk("nom_busy_at_done", busy, 0);
    chk("nom_fail", fail, 0);
    chk("nom_phase_idx", phase_idx, 6);
    tick(2);
    chk("nom_starts", nst, 6);
    chk("nom_done_pulses", ndone_p, 1);
    chk("nom_max_inflight", max_inf, 2);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("nom_block%0d", j), blk[j], 24 * j);
      chk($sformatf("nom_rows%0d", j), rws[j], 4 * j);
    end
    host_req = 1'b1;
    tick(1);
    chk("host_gnt_end", host_gnt, 1);
    host_req = 1'b0;

    fail_on = 3;
    do_reset;
    pulse_start;
    wait_done("fail_done");
    chk("fail_flag", fail, 1);
    chk("fail_dones_before_done", done_dn, 3);
    tick(40);
    chk("fail_starts", nst, 3);
    chk("fail_phase_idx", phase_idx, 3);
    chk("fail_done_pulses", ndone_p, 1);
    chk("fail_sticky", fail, 1);
    fail_on = 0;

    bp_mode = 1'b1;
    do_reset;
    pulse_start;
    wait_done("bp_done");
    chk("bp_no_start_while_low", bp_viol, 0);
    chk("bp_resume_block", blk[1], 24);
    chk("bp_gap", (scyc[1] - scyc[0]) >= 50, 1);
    chk("bp_starts", nst, 6);
    chk("bp_fail", fail, 0);
    bp_mode = 1'b0;

    fail_last = 1'b1;
    do_reset;
    pulse_start;
    wait_done("simul_done");
    chk("simul_fail", fail, 1);
    chk("simul_cmp", done_dn, 6);
    chk("simul_phase_idx", phase_idx, 6);
    tick(2);
    chk("simul_done_pulses", ndone_p, 1);
    fail_last = 1'b0;

    pulse_start;
    chk("fail_cleared_on_start", fail, 0);
    chk("idx_cleared_on_start", phase_idx, 0);
    wait_nst(10, "arst_phase3_issued");
    chk("arst_pre_block", ph_start_block, 72);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {busy, done, fail, phase_idx, ph_start, ph_start_block, ph_rows, host_gnt}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    pulse_start;
    wait_nst(1, "arst_restart_issued");
    chk("arst_restart_block", blk[0], 0);
    chk("arst_restart_rows", rws[0], 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
